// File: rtl/ifu_imem_resp.sv
// IFU instruction-memory responder: in-order line reads with a fixed read pipeline.
// Latency AR->R is RD_LATENCY+2 cycles when idle; R stalls are absorbed by credit-limited issue.

// Count-based FIFO with wrapping pointers; one entry in/out per cycle, zero-cycle read of the head.
// Push while full and pop while empty are ignored; callers gate both with the exported count.
module ifu_imem_resp_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        push_dat,
  input  logic                pop,
  output logic [W-1:0]        pop_dat,
  output logic [DEPTH_BITS:0] count
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                  full, empty, do_push, do_pop;

  assign full    = (cnt_q == (DEPTH_BITS+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (DEPTH_BITS+1)'(1);
      2'b01:   cnt_d = cnt_q - (DEPTH_BITS+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// Top: request FIFO -> credit-gated issue -> RD_LATENCY read pipeline -> response FIFO.
// Issue only while resp entries plus in-flight reads leave a free slot, so R backpressure never drops data.
module ifu_imem_resp #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int RD_LATENCY     = 2,
  parameter int REQ_FIFO_BITS  = 2,
  parameter int RESP_FIFO_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_ar,
  input  logic                      bus_ar_valid,
  output logic                      bus_ar_ready,
  output logic                      bus_r_valid,
  input  logic                      bus_r_ready,
  output logic [DATA_WIDTH-1:0]     bus_r_data,
  output logic                      bus_r_err,
  input  logic                      mem_wr_en,
  input  logic [MEM_DEPTH_BITS-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic [31:0]               req_served
);
  localparam int REQ_DEPTH  = 1 << REQ_FIFO_BITS;
  localparam int RESP_DEPTH = 1 << RESP_FIFO_BITS;
  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_BITS;
  localparam int CW         = 16;

  logic [ADDR_WIDTH-1:0]     req_head;
  logic [REQ_FIFO_BITS:0]    req_count;
  logic                      req_push, req_full, req_empty;
  logic [DATA_WIDTH:0]       resp_head;
  logic [RESP_FIFO_BITS:0]   resp_count;
  logic                      resp_pop;
  logic                      head_err, issue;
  logic [MEM_DEPTH_BITS-1:0] head_idx;
  logic [CW-1:0]             credit_used;

  logic [RD_LATENCY-1:0]     pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]     pipe_err_q, pipe_err_d;
  logic [DATA_WIDTH-1:0]     pipe_dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
  logic [31:0]               req_served_q, req_served_d;

  assign req_full     = (req_count == (REQ_FIFO_BITS+1)'(REQ_DEPTH));
  assign req_empty    = (req_count == '0);
  // Ready depends only on stored occupancy, never on a same-cycle pop.
  assign bus_ar_ready = !rst && !req_full;
  assign req_push     = bus_ar_valid && bus_ar_ready;

  ifu_imem_resp_fifo #(.W(ADDR_WIDTH), .DEPTH_BITS(REQ_FIFO_BITS)) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_push),
    .push_dat (bus_ar),
    .pop      (issue),
    .pop_dat  (req_head),
    .count    (req_count)
  );

  assign head_err = |req_head[ADDR_WIDTH-1:MEM_DEPTH_BITS];
  assign head_idx = req_head[MEM_DEPTH_BITS-1:0];

  always_comb begin
    credit_used = CW'(resp_count);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + CW'(pipe_vld_q[i]);
    end
    issue = !req_empty && (credit_used < CW'(RESP_DEPTH));
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_err_d    = '0;
    pipe_vld_d[0] = issue;
    pipe_err_d[0] = head_err;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
    end
  end

  // Non-blocking write and read on the same edge give read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[mem_wr_addr] <= mem_wr_data;
    if (issue) begin
      if (head_err) pipe_dat_q[0] <= '0;
      else          pipe_dat_q[0] <= mem_q[head_idx];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_dat_q[i] <= pipe_dat_q[i-1];
    end
  end

  assign bus_r_valid = (resp_count != '0);
  assign resp_pop    = bus_r_valid && bus_r_ready;

  ifu_imem_resp_fifo #(.W(DATA_WIDTH+1), .DEPTH_BITS(RESP_FIFO_BITS)) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_vld_q[RD_LATENCY-1]),
    .push_dat ({pipe_err_q[RD_LATENCY-1], pipe_dat_q[RD_LATENCY-1]}),
    .pop      (resp_pop),
    .pop_dat  (resp_head),
    .count    (resp_count)
  );

  assign bus_r_data = bus_r_valid ? resp_head[DATA_WIDTH-1:0] : '0;
  assign bus_r_err  = bus_r_valid && resp_head[DATA_WIDTH];

  always_comb begin
    req_served_d = req_served_q;
    if (resp_pop) req_served_d = req_served_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) req_served_q <= '0;
    else     req_served_q <= req_served_d;
  end

  assign req_served = req_served_q;
endmodule

// File: tb/tb_ifu_imem_resp.sv
// Directed bench for ifu_imem_resp: latency, throughput, stall, range error, write collision, reset.
module tb_ifu_imem_resp;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [47:0]  bus_ar = '0;
  logic         bus_ar_valid = 1'b0;
  logic         bus_ar_ready;
  logic         bus_r_valid;
  logic         bus_r_ready = 1'b0;
  logic [127:0] bus_r_data;
  logic         bus_r_err;
  logic         mem_wr_en = 1'b0;
  logic [9:0]   mem_wr_addr = '0;
  logic [127:0] mem_wr_data = '0;
  logic [31:0]  req_served;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  logic rdy_req = 1'b0;
  logic [47:0]  ar_q[$];
  logic [128:0] got_q[$];
  int           got_cyc[$];

  always #5 clk = ~clk;

  ifu_imem_resp #(
    .ADDR_WIDTH(48), .DATA_WIDTH(128), .MEM_DEPTH_BITS(10),
    .RD_LATENCY(2), .REQ_FIFO_BITS(2), .RESP_FIFO_BITS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_ar       (bus_ar),
    .bus_ar_valid (bus_ar_valid),
    .bus_ar_ready (bus_ar_ready),
    .bus_r_valid  (bus_r_valid),
    .bus_r_ready  (bus_r_ready),
    .bus_r_data   (bus_r_data),
    .bus_r_err    (bus_r_err),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .req_served   (req_served)
  );

  // Preloaded line i holds the byte 0xA0+i in every byte position.
  function automatic logic [127:0] line(input int i);
    logic [7:0] b;
    b = 8'(32'hA0 + i);
    return {16{b}};
  endfunction

  // One clock: drive after the edge, observe at the falling edge.
  task automatic step(input bit wr = 1'b0, input logic [9:0] wa = '0, input logic [127:0] wd = '0);
    @(posedge clk);
    #1;
    cyc_cnt++;
    mem_wr_en   = wr;
    mem_wr_addr = wa;
    mem_wr_data = wd;
    bus_r_ready = rdy_req;
    if (ar_q.size() > 0) begin
      bus_ar       = ar_q[0];
      bus_ar_valid = 1'b1;
    end else begin
      bus_ar_valid = 1'b0;
    end
    @(negedge clk);
    if (bus_ar_valid && bus_ar_ready) void'(ar_q.pop_front());
    if (bus_r_valid && bus_r_ready) begin
      got_q.push_back({bus_r_err, bus_r_data});
      got_cyc.push_back(cyc_cnt);
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_ar_valid = 1'b0;
    mem_wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_ar_ready !== 1'b0) begin errors++; $display("FAIL reset_ar_ready got=%b exp=0", bus_ar_ready); end
    checks++; if (bus_r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got=%b exp=0", bus_r_valid); end
    checks++; if (bus_r_data !== 128'd0) begin errors++; $display("FAIL reset_r_data got=%h exp=0", bus_r_data); end
    checks++; if (bus_r_err !== 1'b0) begin errors++; $display("FAIL reset_r_err got=%b exp=0", bus_r_err); end
    checks++; if (req_served !== 32'd0) begin errors++; $display("FAIL reset_req_served got=%0d exp=0", req_served); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_ar_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ar_ready got=%b exp=1", bus_ar_ready); end
  endtask

  task automatic preload();
    for (int i = 0; i < 10; i++) step(1'b1, 10'(i), line(i));
    step();
  endtask

  task automatic test_single_latency();
    int base;
    logic [128:0] r;
    rdy_req = 1'b1;
    clear_got();
    ar_q.push_back(48'd5);
    base = cyc_cnt + 1;
    repeat (12) step();
    checks++; if (ar_q.size() != 0) begin errors++; $display("FAIL single_ar_accept pending=%0d exp=0", ar_q.size()); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      r = got_q[0];
      checks++; if (got_cyc[0] - base != 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", got_cyc[0] - base); end
      checks++; if (r[127:0] !== {16{8'hA5}}) begin errors++; $display("FAIL single_data got=%h exp=%h", r[127:0], {16{8'hA5}}); end
      checks++; if (r[128] !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", r[128]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    rdy_req = 1'b1;
    clear_got();
    for (int i = 0; i < 6; i++) ar_q.push_back(48'(i));
    n = 0;
    while (got_q.size() < 6 && n < 30) begin step(); n++; end
    repeat (2) step();
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i] !== {1'b0, line(i)}) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], {1'b0, line(i)}); end
    end
    for (int i = 1; i < got_cyc.size() && i < 6; i++) begin
      checks++;
      if (got_cyc[i] - got_cyc[0] != i) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, got_cyc[i] - got_cyc[0], i); end
    end
    checks++; if (req_served !== 32'd6) begin errors++; $display("FAIL b2b_req_served got=%0d exp=6", req_served); end
  endtask

  task automatic test_stall();
    int n;
    int unstable;
    rdy_req = 1'b0;
    clear_got();
    for (int i = 0; i < 8; i++) ar_q.push_back(48'(i));
    unstable = 0;
    repeat (20) begin
      step();
      if (bus_r_valid && {bus_r_err, bus_r_data} !== {1'b0, line(0)}) unstable++;
    end
    checks++; if (ar_q.size() != 0) begin errors++; $display("FAIL stall_all_accepted pending=%0d exp=0", ar_q.size()); end
    checks++; if (bus_ar_ready !== 1'b0) begin errors++; $display("FAIL stall_ar_ready got=%b exp=0", bus_ar_ready); end
    checks++; if (bus_r_valid !== 1'b1) begin errors++; $display("FAIL stall_r_valid got=%b exp=1", bus_r_valid); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_data_stable changed_cycles=%0d exp=0", unstable); end
    rdy_req = 1'b1;
    n = 0;
    while (got_q.size() < 8 && n < 40) begin step(); n++; end
    repeat (5) step();
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stall_release_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i] !== {1'b0, line(i)}) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got_q[i], {1'b0, line(i)}); end
    end
  endtask

  task automatic test_range_err();
    int n;
    rdy_req = 1'b1;
    clear_got();
    ar_q.push_back(48'd1);
    ar_q.push_back(48'h400);
    ar_q.push_back(48'd2);
    n = 0;
    while (got_q.size() < 3 && n < 30) begin step(); n++; end
    repeat (3) step();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL range_count got=%0d exp=3", got_q.size()); end
    if (got_q.size() == 3) begin
      checks++; if (got_q[0] !== {1'b0, line(1)}) begin errors++; $display("FAIL range_first got=%h exp=%h", got_q[0], {1'b0, line(1)}); end
      checks++; if (got_q[1] !== {1'b1, 128'd0}) begin errors++; $display("FAIL range_err_resp got=%h exp=%h", got_q[1], {1'b1, 128'd0}); end
      checks++; if (got_q[2] !== {1'b0, line(2)}) begin errors++; $display("FAIL range_third got=%h exp=%h", got_q[2], {1'b0, line(2)}); end
    end
  endtask

  task automatic test_rw_collision();
    int n;
    logic [127:0] xval;
    xval = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    rdy_req = 1'b1;
    clear_got();
    ar_q.push_back(48'd7);
    step();
    checks++; if (ar_q.size() != 0) begin errors++; $display("FAIL coll_ar_accept pending=%0d exp=0", ar_q.size()); end
    step(1'b1, 10'd7, xval);
    n = 0;
    while (got_q.size() < 1 && n < 20) begin step(); n++; end
    repeat (2) step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL coll_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== {1'b0, {16{8'hA7}}}) begin errors++; $display("FAIL coll_old_data got=%h exp=%h", got_q[0], {1'b0, {16{8'hA7}}}); end
    end
    clear_got();
    ar_q.push_back(48'd7);
    n = 0;
    while (got_q.size() < 1 && n < 20) begin step(); n++; end
    repeat (2) step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL coll_reread_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== {1'b0, xval}) begin errors++; $display("FAIL coll_new_data got=%h exp=%h", got_q[0], {1'b0, xval}); end
    end
  endtask

  task automatic test_mid_reset();
    rdy_req = 1'b1;
    clear_got();
    ar_q.push_back(48'd1);
    ar_q.push_back(48'd2);
    ar_q.push_back(48'd3);
    repeat (3) step();
    checks++; if (ar_q.size() != 0) begin errors++; $display("FAIL midrst_ar_accept pending=%0d exp=0", ar_q.size()); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_ar_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_ar_ready !== 1'b1) begin errors++; $display("FAIL midrst_ar_ready got=%b exp=1", bus_ar_ready); end
    checks++; if (bus_r_valid !== 1'b0) begin errors++; $display("FAIL midrst_r_valid got=%b exp=0", bus_r_valid); end
    checks++; if (req_served !== 32'd0) begin errors++; $display("FAIL midrst_req_served got=%0d exp=0", req_served); end
    repeat (10) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_no_resp got=%0d exp=0", got_q.size()); end
    checks++; if (req_served !== 32'd0) begin errors++; $display("FAIL midrst_served_after got=%0d exp=0", req_served); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload();
    test_single_latency();
    test_back_to_back();
    test_stall();
    test_range_err();
    test_rw_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
